// File: rtl/dual_fifo_pkg.sv
// Shared constants and width helper for the dual FIFO bridge.
// Optional sticky error flags are enabled by defining DUAL_FIFO_ERR_FLAGS_EN.
package dual_fifo_pkg;

  localparam int DEF_WIDTH     = 128;
  localparam int DEF_DEPTH     = 4096;
  localparam int DEF_AF_MARGIN = 4;
  localparam int DEF_AE_MARGIN = 4;

  // Occupancy needs one extra bit so that count == DEPTH is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO with occupancy count, registered flags, synchronous flush.
// Sticky overflow/underflow outputs exist only when DUAL_FIFO_ERR_FLAGS_EN is defined.
module sync_fifo_core
  import dual_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_MARGIN = DEF_AF_MARGIN,
  parameter int AE_MARGIN = DEF_AE_MARGIN
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [cnt_width(DEPTH)-1:0]  count
`ifdef DUAL_FIFO_ERR_FLAGS_EN
  ,
  output logic                         overflow,
  output logic                         underflow
`endif
);

  localparam int CW = cnt_width(DEPTH);
  localparam int PW = CW - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;
  logic [CW-1:0]    count_next;
  logic [CW-1:0]    free_next;

  // Both requests are judged against the flags registered before this edge.
  assign push_ok    = push & ~full;
  assign pop_ok     = pop & ~empty;
  assign count_next = count + {{(CW-1){1'b0}}, push_ok} - {{(CW-1){1'b0}}, pop_ok};
  assign free_next  = CW'(DEPTH) - count_next;

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      pop_data     <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      pop_data     <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok) begin
        rd_ptr   <= rd_ptr + PW'(1);
        pop_data <= mem[rd_ptr];
      end
      count        <= count_next;
      full         <= (count_next == CW'(DEPTH));
      empty        <= (count_next == '0);
      almost_full  <= (int'(free_next) <= AF_MARGIN);
      almost_empty <= (int'(count_next) <= AE_MARGIN);
    end
  end

`ifdef DUAL_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && full) overflow <= 1'b1;
      if (pop && empty) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/dual_fifo_bridge.sv
// Tx (CPU -> decoder) and Rx (decoder -> CPU) FIFOs on one clock; wiring only.
// Define DUAL_FIFO_ERR_FLAGS_EN to expose sticky overflow/underflow flags.
module dual_fifo_bridge
  import dual_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int TX_DEPTH  = DEF_DEPTH,
  parameter int RX_DEPTH  = DEF_DEPTH,
  parameter int AF_MARGIN = DEF_AF_MARGIN,
  parameter int AE_MARGIN = DEF_AE_MARGIN
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic [WIDTH-1:0]                wr_data,
  output logic                            full,
  output logic                            tx_almost_full,
  output logic [cnt_width(TX_DEPTH)-1:0]  tx_count,
  input  logic                            tx_flush,
  input  logic                            READ_ENABLE,
  output logic [WIDTH-1:0]                READ_DATA,
  output logic                            FIFO_EMPTY,
  input  logic                            WRITE_ENABLE,
  input  logic [WIDTH-1:0]                WRITE_DATA,
  output logic                            FIFO_FULL,
  input  logic                            rd_en,
  output logic [WIDTH-1:0]                rd_data,
  output logic                            empty,
  output logic                            rx_almost_empty,
  output logic [cnt_width(RX_DEPTH)-1:0]  rx_count,
  input  logic                            rx_flush
`ifdef DUAL_FIFO_ERR_FLAGS_EN
  ,
  output logic                            tx_overflow,
  output logic                            tx_underflow,
  output logic                            rx_overflow,
  output logic                            rx_underflow
`endif
);

  // Flags not exposed at the top are left open on purpose.
  logic tx_almost_empty_nc;
  logic rx_almost_full_nc;

  sync_fifo_core #(
    .WIDTH(WIDTH), .DEPTH(TX_DEPTH), .AF_MARGIN(AF_MARGIN), .AE_MARGIN(AE_MARGIN)
  ) u_tx (
    .clk(clk), .rst(rst),
    .push(wr_en), .push_data(wr_data),
    .pop(READ_ENABLE), .flush(tx_flush),
    .pop_data(READ_DATA),
    .full(full), .empty(FIFO_EMPTY),
    .almost_full(tx_almost_full), .almost_empty(tx_almost_empty_nc),
    .count(tx_count)
`ifdef DUAL_FIFO_ERR_FLAGS_EN
    , .overflow(tx_overflow), .underflow(tx_underflow)
`endif
  );

  sync_fifo_core #(
    .WIDTH(WIDTH), .DEPTH(RX_DEPTH), .AF_MARGIN(AF_MARGIN), .AE_MARGIN(AE_MARGIN)
  ) u_rx (
    .clk(clk), .rst(rst),
    .push(WRITE_ENABLE), .push_data(WRITE_DATA),
    .pop(rd_en), .flush(rx_flush),
    .pop_data(rd_data),
    .full(FIFO_FULL), .empty(empty),
    .almost_full(rx_almost_full_nc), .almost_empty(rx_almost_empty),
    .count(rx_count)
`ifdef DUAL_FIFO_ERR_FLAGS_EN
    , .overflow(rx_overflow), .underflow(rx_underflow)
`endif
  );

endmodule
